instr_loader: RTL and testbench

Boot-time instruction loader that sits directly upstream of the single-cycle core's instruction-memory write port (`instr_in`, `instr_wr_addr`, `instr_wr_en`). It accepts a byte stream over a valid/ready handshake, reads a 16-bit word-count header, assembles little-endian 32-bit instructions and writes them to consecutive word addresses. It holds the core in reset until the image is fully written, then releases it.

---
 rtl/instr_loader.sv | 151 +++++++++++++++
 tb/tb_instr_loader.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time instruction loader: receives a byte stream with a 16-bit
// little-endian word-count header, assembles little-endian 32-bit words and
// writes them to consecutive word addresses of the core's instruction memory.
// The core is held in reset until a complete image has been written.
module instr_loader #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 64,
  localparam int LOGSIZE = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic [WIDTH-1:0]   instr_in,
  output logic [LOGSIZE+1:0] instr_wr_addr,
  output logic               instr_wr_en,
  output logic               core_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    LOAD,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int          WPAD   = 16 - LOGSIZE;
  localparam logic [16:0] SIZE_W = 17'(SIZE);

  state_t             state;
  state_t             state_next;
  logic [15:0]        count;
  logic [1:0]         byte_idx;
  logic [LOGSIZE-1:0] word_idx;
  logic [WIDTH-1:0]   word_reg;
  logic [15:0]        hdr_count;
  logic [15:0]        words_written;

  // Full header value as it would be once the high byte is taken this cycle.
  assign hdr_count     = {byte_in, count[7:0]};
  // Number of words written once the current WRITE cycle completes.
  assign words_written = {{WPAD{1'b0}}, word_idx} + 16'd1;

  // State register; reset returns to IDLE from anywhere, even mid-load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; byte-consuming states only advance on an accepted byte.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (load_start) state_next = HDR0;
      end
      HDR0: begin
        if (byte_valid) state_next = HDR1;
      end
      HDR1: begin
        if (byte_valid) begin
          if (hdr_count == 16'd0) begin
            state_next = DONE;
          end else if ({1'b0, hdr_count} > SIZE_W) begin
            state_next = ERR;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (byte_valid && (byte_idx == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        if (words_written == count) begin
          state_next = DONE;
        end else begin
          state_next = LOAD;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Header capture, byte assembly and write-port registers; the write data and
  // address are captured with the fourth byte so they are stable during WRITE
  // and simply hold afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count         <= '0;
      byte_idx      <= '0;
      word_idx      <= '0;
      word_reg      <= '0;
      instr_in      <= '0;
      instr_wr_addr <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            byte_idx <= '0;
            word_idx <= '0;
          end
        end
        HDR0: begin
          if (byte_valid) count[7:0] <= byte_in;
        end
        HDR1: begin
          if (byte_valid) begin
            count[15:8] <= byte_in;
            byte_idx    <= '0;
            word_idx    <= '0;
          end
        end
        LOAD: begin
          if (byte_valid) begin
            word_reg[{byte_idx, 3'b000} +: 8] <= byte_in;
            byte_idx                          <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              instr_in      <= {byte_in, word_reg[23:0]};
              instr_wr_addr <= {word_idx, 2'b00};
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign byte_ready  = (state == HDR0) || (state == HDR1) || (state == LOAD);
  assign busy        = byte_ready || (state == WRITE);
  assign instr_wr_en = (state == WRITE);
  assign done        = (state == DONE);
  assign error       = (state == ERR);
  assign core_reset  = (state != DONE);

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a stream-position reference model is
// compared against every DUT output on each falling edge, and directed loads
// pin the model with hand-computed write data, addresses and latencies.
module tb_instr_loader;

  localparam int SIZE = 64;
  localparam logic [2:0] P_IDLE = 3'd0;
  localparam logic [2:0] P_ACT  = 3'd1;
  localparam logic [2:0] P_DONE = 3'd2;
  localparam logic [2:0] P_ERR  = 3'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] instr_in;
  logic [7:0]  instr_wr_addr;
  logic        instr_wr_en;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        error;

  instr_loader #(.WIDTH(32), .SIZE(SIZE)) dut (
    .clk           (clk),
    .reset         (reset),
    .load_start    (load_start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .instr_in      (instr_in),
    .instr_wr_addr (instr_wr_addr),
    .instr_wr_en   (instr_wr_en),
    .core_reset    (core_reset),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  // Model state: where the loader is in the byte stream, not how it is encoded.
  typedef struct packed {
    logic [2:0]  phase;
    logic [15:0] acc;
    logic        writing;
    logic [15:0] n;
    logic [7:0]  lo;
    logic [31:0] asm_word;
    logic [31:0] last_data;
    logic [7:0]  last_addr;
  } model_t;

  model_t      m;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic        prev_core = 1'b1;
  logic [7:0]  stream[$];
  logic [7:0]  wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          fall_log[$];

  function automatic model_t modelStep(model_t c, logic ls, logic bv, logic [7:0] b);
    model_t x;
    int pos;
    int k;
    x = c;
    if (c.phase != P_ACT) begin
      if (ls) begin
        x.phase   = P_ACT;
        x.acc     = 16'd0;
        x.writing = 1'b0;
      end
    end else if (c.writing) begin
      x.writing = 1'b0;
      if ((int'(c.acc) - 2) / 4 == int'(c.n)) x.phase = P_DONE;
    end else if (bv) begin
      x.acc = c.acc + 16'd1;
      if (c.acc == 16'd0) begin
        x.lo = b;
      end else if (c.acc == 16'd1) begin
        x.n = {b, c.lo};
        if (x.n == 16'd0) x.phase = P_DONE;
        else if (int'(x.n) > SIZE) x.phase = P_ERR;
      end else begin
        pos = int'(c.acc) - 2;
        k   = pos % 4;
        x.asm_word[8*k +: 8] = b;
        if (k == 3) begin
          x.writing   = 1'b1;
          x.last_data = x.asm_word;
          x.last_addr = 8'((pos / 4) * 4);
        end
      end
    end
    return x;
  endfunction

  // Reference model advances on the same edges and reset as the DUT.
  always @(posedge clk or posedge reset) begin
    if (reset) m <= '0;
    else       m <= modelStep(m, load_start, byte_valid, byte_in);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, plus a log of
  // write strobes and core_reset falling edges for the directed checks.
  always @(negedge clk) begin
    checkOutput("busy",          32'(busy),          32'(m.phase == P_ACT));
    checkOutput("byte_ready",    32'(byte_ready),    32'((m.phase == P_ACT) && !m.writing));
    checkOutput("instr_wr_en",   32'(instr_wr_en),   32'(m.writing));
    checkOutput("instr_in",      instr_in,           m.last_data);
    checkOutput("instr_wr_addr", 32'(instr_wr_addr), 32'(m.last_addr));
    checkOutput("done",          32'(done),          32'(m.phase == P_DONE));
    checkOutput("error",         32'(error),         32'(m.phase == P_ERR));
    checkOutput("core_reset",    32'(core_reset),    32'(m.phase != P_DONE));
    if (instr_wr_en) begin
      wr_addr_log.push_back(instr_wr_addr);
      wr_data_log.push_back(instr_in);
    end
    if (prev_core && !core_reset) fall_log.push_back(cyc);
    prev_core <= core_reset;
  end

  function automatic logic [31:0] logData(int i);
    return (i < wr_data_log.size()) ? wr_data_log[i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] logAddr(int i);
    return (i < wr_addr_log.size()) ? 32'(wr_addr_log[i]) : 32'hxxxxxxxx;
  endfunction

  function automatic int fallLatency();
    return (fall_log.size() > 0) ? fall_log[0] - start_cyc : -1;
  endfunction

  task automatic clearLog();
    wr_addr_log.delete();
    wr_data_log.delete();
    fall_log.delete();
  endtask

  task automatic pushHeader(int n);
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
  endtask

  task automatic pushWord(logic [31:0] w);
    for (int k = 0; k < 4; k++) stream.push_back(w[8*k +: 8]);
  endtask

  task automatic startLoad();
    @(negedge clk);
    byte_valid = 1'b0;
    load_start = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Present stream bytes until stop_after have been accepted; pct<0 toggles
  // byte_valid every cycle, pulse_pct sets how often load_start is waved
  // while the loader is busy.
  task automatic applyStimulus(int pct, int pulse_pct, int stop_after);
    int  i;
    int  guard;
    logic tog;
    logic took;
    i = 0;
    guard = 0;
    tog = 1'b0;
    while (i < stop_after && guard < 5000) begin
      byte_in = stream[i];
      if (pct < 0) begin
        byte_valid = tog;
        tog = ~tog;
      end else begin
        byte_valid = ($urandom_range(0, 99) < pct);
      end
      load_start = (m.phase == P_ACT) && ($urandom_range(0, 99) < pulse_pct);
      took = byte_valid && byte_ready;
      @(posedge clk);
      if (took) i++;
      @(negedge clk);
      guard++;
    end
    byte_valid = 1'b0;
    load_start = 1'b0;
    tests++;
    if (i < stop_after) begin
      fails++;
      $display("[TB] FAIL stream_accept: got %0d bytes accepted, expected %0d", i, stop_after);
    end
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (m.phase == P_ACT && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (m.phase == P_ACT) begin
      fails++;
      $display("[TB] FAIL load_timeout: got still busy after %0d cycles, expected load end", guard);
    end
    // Offer bytes while not loading; they must not be consumed.
    for (int k = 0; k < 3; k++) begin
      byte_in    = 8'($urandom);
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_byte_ready"},  32'(byte_ready),    32'd0);
    checkOutput({tag, "_wr_en"},       32'(instr_wr_en),   32'd0);
    checkOutput({tag, "_busy"},        32'(busy),          32'd0);
    checkOutput({tag, "_done"},        32'(done),          32'd0);
    checkOutput({tag, "_error"},       32'(error),         32'd0);
    checkOutput({tag, "_instr_in"},    instr_in,           32'd0);
    checkOutput({tag, "_wr_addr"},     32'(instr_wr_addr), 32'd0);
    checkOutput({tag, "_core_reset"},  32'(core_reset),    32'd1);
  endtask

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] words[$];
    int n;
    int r;

    #1 reset = 1'b1;
    #20;
    checkResetValues("por");
    @(negedge clk);
    reset = 1'b0;

    // Two-word image from the reference stream.
    pushHeader(2);
    pushWord(32'h00100513);
    pushWord(32'h00200593);
    clearLog();
    startLoad();
    applyStimulus(100, 0, stream.size());
    waitIdle();
    checkOutput("n2_write_count", 32'(wr_data_log.size()), 32'd2);
    checkOutput("n2_data0", logData(0), 32'h00100513);
    checkOutput("n2_addr0", logAddr(0), 32'd0);
    checkOutput("n2_data1", logData(1), 32'h00200593);
    checkOutput("n2_addr1", logAddr(1), 32'd4);
    checkOutput("n2_release_latency", 32'(fallLatency()), 32'd13);
    checkOutput("n2_done", 32'(done), 32'd1);
    checkOutput("n2_core_reset", 32'(core_reset), 32'd0);

    // Empty image: done after the two header bytes, no writes.
    pushHeader(0);
    clearLog();
    startLoad();
    checkOutput("n0_restart_core_reset", 32'(core_reset), 32'd1);
    applyStimulus(100, 0, stream.size());
    waitIdle();
    checkOutput("n0_write_count", 32'(wr_data_log.size()), 32'd0);
    checkOutput("n0_release_latency", 32'(fallLatency()), 32'd3);
    checkOutput("n0_done", 32'(done), 32'd1);

    // Oversized image is rejected without writes.
    pushHeader(65);
    clearLog();
    startLoad();
    applyStimulus(100, 0, stream.size());
    waitIdle();
    checkOutput("n65_write_count", 32'(wr_data_log.size()), 32'd0);
    checkOutput("n65_error", 32'(error), 32'd1);
    checkOutput("n65_done", 32'(done), 32'd0);
    checkOutput("n65_core_reset", 32'(core_reset), 32'd1);

    // Single word with byte_valid toggling; restart also clears error.
    w1 = $urandom;
    pushHeader(1);
    pushWord(w1);
    clearLog();
    startLoad();
    checkOutput("restart_clears_error", 32'(error), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    applyStimulus(-1, 0, stream.size());
    waitIdle();
    checkOutput("toggle_write_count", 32'(wr_data_log.size()), 32'd1);
    checkOutput("toggle_data0", logData(0), w1);
    checkOutput("toggle_addr0", logAddr(0), 32'd0);
    checkOutput("toggle_done", 32'(done), 32'd1);

    // Asynchronous reset after the second data byte, then a fresh load.
    w1 = $urandom;
    pushHeader(1);
    pushWord(w1);
    clearLog();
    startLoad();
    applyStimulus(100, 0, 4);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkResetValues("midload");
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midload_write_count", 32'(wr_data_log.size()), 32'd0);
    w2 = $urandom;
    pushHeader(1);
    pushWord(w2);
    clearLog();
    startLoad();
    applyStimulus(100, 0, stream.size());
    waitIdle();
    checkOutput("after_reset_data0", logData(0), w2);
    checkOutput("after_reset_addr0", logAddr(0), 32'd0);
    checkOutput("after_reset_done", 32'(done), 32'd1);

    // load_start held through a busy load has no effect; then reload N=1.
    w1 = $urandom;
    w2 = $urandom;
    pushHeader(2);
    pushWord(w1);
    pushWord(w2);
    clearLog();
    startLoad();
    applyStimulus(100, 100, stream.size());
    waitIdle();
    checkOutput("pulse_write_count", 32'(wr_data_log.size()), 32'd2);
    checkOutput("pulse_data1", logData(1), w2);
    checkOutput("pulse_addr1", logAddr(1), 32'd4);
    w1 = $urandom;
    pushHeader(1);
    pushWord(w1);
    clearLog();
    startLoad();
    checkOutput("reload_core_reset", 32'(core_reset), 32'd1);
    checkOutput("reload_done_cleared", 32'(done), 32'd0);
    applyStimulus(100, 0, stream.size());
    waitIdle();
    checkOutput("reload_data0", logData(0), w1);
    checkOutput("reload_addr0", logAddr(0), 32'd0);
    checkOutput("reload_done", 32'(done), 32'd1);

    // Randomized loads of varied sizes, stalls and stray load_start pulses.
    for (int t = 0; t < 12; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = 0;
      else if (r == 1) n = $urandom_range(65, 300);
      else if (r == 2) n = SIZE;
      else             n = $urandom_range(1, 8);
      pushHeader(n);
      words.delete();
      if (n <= SIZE) begin
        for (int k = 0; k < n; k++) begin
          words.push_back($urandom);
          pushWord(words[k]);
        end
      end
      clearLog();
      startLoad();
      applyStimulus($urandom_range(25, 100), 10, stream.size());
      waitIdle();
      checkOutput("rand_write_count", 32'(wr_data_log.size()), (n <= SIZE) ? 32'(n) : 32'd0);
      checkOutput("rand_error", 32'(error), 32'(n > SIZE));
      for (int k = 0; k < words.size(); k++) begin
        checkOutput("rand_data", logData(k), words[k]);
        checkOutput("rand_addr", logAddr(k), 32'(4 * k));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
